serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor that computes diff = a - b, processing one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Complements the existing combinational half-adder datapath: it is the subtract direction, built as a small sequential block.
- Operands are accepted through a valid/ready handshake, and the result is returned through a second valid/ready handshake.
- Used where area matters more than latency, e.g. small counters or comparators in later exercises.

---
 rtl/serial_sub_pkg.sv | 20 ++
 rtl/full_subtractor_cell.sv | 22 ++
 rtl/serial_subtractor.sv | 162 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared types and helpers for the bit-serial subtractor.
//   state_t   : FSM state encoding (IDLE, SHIFT, DONE), 2-bit logic enum
//   cnt_width : width of the bit counter needed to count 0 .. w-1
// -----------------------------------------------------------------------------
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // $clog2(1) is 0, so never return less than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// -----------------------------------------------------------------------------
// full_subtractor_cell
// One-bit full subtractor: computes x - y - bin.
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow in from the less significant bit
//   d    : difference bit
//   bout : borrow out to the more significant bit
// -----------------------------------------------------------------------------
module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  // Borrow when y exceeds x outright, or when x == y and a borrow is pending.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor, diff = a - b, one bit per clock, LSB first,
// through a single full_subtractor_cell and a borrow flip-flop.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1. Input side: in_valid/in_ready qualify a/b. Output side:
// out_valid/out_ready qualify diff/borrow, which stay stable while
// out_valid && !out_ready.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   in_valid      : a/b valid          in_ready  : operands can be accepted
//   a, b          : W-bit unsigned minuend / subtrahend
//   out_valid     : diff/borrow valid  out_ready : consumer takes result
//   diff          : a - b modulo 2^W   borrow    : 1 when a < b
//   o_dbg_state   : current FSM state (state_t encoding) for observation
//
// Optional build macro SERIAL_SUB_SAT_EN: when defined, a result with
// borrow = 1 presents diff as all zeros (saturating subtract).
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         borrow,
  output logic [1:0]   o_dbg_state
);

  localparam int CW = cnt_width(W);

  state_t         r_state;
  state_t         w_next_state;

  logic [W-1:0]   r_a_sh;
  logic [W-1:0]   r_b_sh;
  logic [W-1:0]   r_res;
  logic [W-1:0]   r_diff;
  logic [CW-1:0]  r_cnt;
  logic           r_bff;
  logic           r_borrow;

  logic           w_d;
  logic           w_bout;
  logic           w_last;
  logic [W-1:0]   w_res_next;

  full_subtractor_cell u_cell (
    .x    (r_a_sh[0]),
    .y    (r_b_sh[0]),
    .bin  (r_bff),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_last     = (r_cnt == CW'(W - 1));
  // New difference bit enters at the MSB; after W shifts the LSB of the
  // result has travelled down to bit 0.
  assign w_res_next = {w_d, {(W-1){1'b0}}} | (r_res >> 1);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand shifters, result shifter, borrow flop, counter.
  // diff/borrow are separate registers loaded on the last SHIFT cycle so they
  // keep the previous result through IDLE and the next SHIFT.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_bff    <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_cnt  <= '0;
            r_bff  <= 1'b0;
          end
        end
        SHIFT: begin
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_res  <= w_res_next;
          r_bff  <= w_bout;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
`ifdef SERIAL_SUB_SAT_EN
            r_diff <= w_bout ? '0 : w_res_next;
`else
            r_diff <= w_res_next;
`endif
            r_borrow <= w_bout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign diff        = r_diff;
  assign borrow      = r_borrow;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Bench for serial_subtractor (W = 8): directed vector table, reset abort,
// backpressure hold, and 100 back-to-back random operations scored against
// a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic [1:0]   dbg_state;

  serial_subtractor #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .diff        (diff),
    .borrow      (borrow),
    .o_dbg_state (dbg_state)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: unsigned subtract, borrow = (a < b)
  // ---------------------------------------------------------------------------
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
    logic [W-1:0] d;
    logic         br;
    br = (ma < mb);
    d  = ma - mb;
`ifdef SERIAL_SUB_SAT_EN
    if (br) d = '0;
`endif
    return {br, d};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard / monitor, sampled on the falling edge
  // ---------------------------------------------------------------------------
  logic [W:0] exp_q[$];
  int         acc_q[$];
  int         cyc = 0;
  int         in_cnt = 0;
  int         out_cnt = 0;
  int         last_acc = -1;
  bit         b2b_mode = 0;
  logic       prev_ov = 1'b0;
  logic       prev_or = 1'b0;
  logic [W:0] prev_res = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      prev_ov  = 1'b0;
      last_acc = -1;
    end else begin
      if (out_valid && in_ready) chk("ready_with_valid", 1, 0);
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) chk("spurious_out_valid", 1, 0);
        else chk("latency", cyc - acc_q.pop_front(), W + 1);
      end
      if (prev_ov && out_valid && !prev_or) chk("hold_stable", {borrow, diff}, prev_res);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else chk("sb_result", {borrow, diff}, exp_q.pop_front());
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b));
        acc_q.push_back(cyc);
        if (b2b_mode && last_acc >= 0) chk("b2b_interval", cyc - last_acc, W + 2);
        last_acc = cyc;
        in_cnt++;
      end
      prev_ov  = out_valid;
      prev_or  = out_ready;
      prev_res = {borrow, diff};
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_accept(output bit ok);
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input int hold,
                       output logic [W-1:0] rd, output logic rb);
    bit ok;
    logic [W:0] held;
    @(posedge clk); #1;
    a = oa; b = ob; in_valid = 1'b1; out_ready = (hold == 0);
    wait_accept(ok);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom_range(0, 255));   // ignored while busy
    b = W'($urandom_range(0, 255));
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("out_valid_timeout", 0, 1);
    held = {borrow, diff};
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_stable", {borrow, diff}, held);
    end
    if (!out_ready) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
    end
    rd = diff;
    rb = borrow;
    @(negedge clk);
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_out_valid", out_valid, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] vd;
    logic         vbr;
    int           hold;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [W-1:0] rd;
    logic         rb;
    logic [W-1:0] exp_d;
    bit           ok;

    tbl[0] = '{8'd5,   8'd3,   8'h02, 1'b0, 0};
    tbl[1] = '{8'd3,   8'd5,   8'hFE, 1'b1, 0};
    tbl[2] = '{8'h00,  8'h01,  8'hFF, 1'b1, 0};
    tbl[3] = '{8'hA5,  8'hA5,  8'h00, 1'b0, 0};
    tbl[4] = '{8'd200, 8'd55,  8'h91, 1'b0, 10};
    tbl[5] = '{8'h00,  8'hFF,  8'h01, 1'b1, 0};
    tbl[6] = '{8'h4D,  8'h00,  8'h4D, 1'b0, 0};
    tbl[7] = '{8'hFF,  8'h00,  8'hFF, 1'b0, 0};
    tbl[8] = '{8'h80,  8'h81,  8'hFF, 1'b1, 2};
    tbl[9] = '{8'h10,  8'h01,  8'h0F, 1'b0, 0};

    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].va, tbl[i].vb, tbl[i].hold, rd, rb);
      exp_d = tbl[i].vd;
`ifdef SERIAL_SUB_SAT_EN
      if (tbl[i].vbr) exp_d = '0;
`endif
      chk($sformatf("tbl%0d_diff", i), rd, exp_d);
      chk($sformatf("tbl%0d_borrow", i), rb, tbl[i].vbr);
    end

    // Reset in the middle of SHIFT aborts with no partial result.
    @(posedge clk); #1;
    a = 8'd9; b = 8'd4; in_valid = 1'b1; out_ready = 1'b1;
    wait_accept(ok);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_diff", diff, 0);
    chk("midrst_borrow", borrow, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      chk("postrst_no_valid", out_valid, 0);
    end
    do_op(8'd9, 8'd4, 0, rd, rb);
    chk("fresh_diff", rd, 5);
    chk("fresh_borrow", rb, 0);

    // Back-to-back random operations with in_valid held high.
    b2b_mode = 1;
    last_acc = -1;
    in_cnt   = 0;
    out_cnt  = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      if (i % 17 == 3) b = a;
      wait_accept(ok);
      if (!ok) break;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (W + 6) @(negedge clk);
    b2b_mode = 0;
    chk("b2b_accepted", in_cnt, 100);
    chk("b2b_results", out_cnt, 100);
    chk("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected completion");
    err_cnt++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $fatal(1, "timeout");
  end

endmodule
